pc_gen_unit: RTL

Parametrised program-counter generator for the IF stage, replacing the plain enable-gated PC register. Selects the next PC from sequential increment, jump, branch or exception redirect under a fixed priority. It also buffers a redirect that arrives while fetch is stalled, and emits a one-cycle flush pulse whenever the PC is redirected. Sits between the EX/MEM redirect sources and instruction memory.

---
 rtl/pc_gen_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pc_gen_unit.sv
// Program-counter generator for IF: sequential/jump/branch/exception select with stall-time redirect buffering.
// Optional build macro ALIGN_CHECK_EN: misaligned br/jmp targets trap to EXC_VEC and pulse misalign_o.
module pc_gen_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0080),
    parameter int              INC       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            jmp_valid_i,
    input  logic [PC_W-1:0] jmp_target_i,
    input  logic            br_valid_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            exc_valid_i,
    output logic [PC_W-1:0] pc_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic            pend_o,
    output logic            misalign_o
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Redirect priority levels; larger wins, zero means no redirect.
    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_JMP  = 2'd1;
    localparam logic [1:0] LVL_BR   = 2'd2;
    localparam logic [1:0] LVL_EXC  = 2'd3;

    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]      pend_lvl_q, pend_lvl_d;
    logic            pend_mis_q, pend_mis_d;

    logic [1:0]      raw_lvl;
    logic [PC_W-1:0] raw_tgt;
    logic            live_valid;
    logic            live_mis;
    logic [1:0]      live_lvl;
    logic [PC_W-1:0] live_tgt;
    logic            live_wins;

    always_comb begin
        raw_lvl = LVL_NONE;
        raw_tgt = jmp_target_i;
        if (exc_valid_i) begin
            raw_lvl = LVL_EXC;
            raw_tgt = EXC_VEC;
        end else if (br_valid_i) begin
            raw_lvl = LVL_BR;
            raw_tgt = br_target_i;
        end else if (jmp_valid_i) begin
            raw_lvl = LVL_JMP;
        end
    end

    assign live_valid = (raw_lvl != LVL_NONE);

`ifdef ALIGN_CHECK_EN
    assign live_mis = (raw_lvl == LVL_BR || raw_lvl == LVL_JMP) && (raw_tgt[1:0] != 2'b00);
`else
    assign live_mis = 1'b0;
`endif

    // A trapped target is promoted to exception level so later redirects compare against it correctly.
    assign live_lvl  = live_mis ? LVL_EXC : raw_lvl;
    assign live_tgt  = live_mis ? {EXC_VEC[PC_W-1:2], 2'b00} : {raw_tgt[PC_W-1:2], 2'b00};
    assign live_wins = live_valid && (live_lvl >= pend_lvl_q);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        pend_tgt_d    = pend_tgt_q;
        pend_lvl_d    = pend_lvl_q;
        pend_mis_d    = pend_mis_q;
        case (state_q)
            S_BOOT: begin
                state_d       = S_RUN;
                fetch_valid_d = 1'b1;
            end
            S_RUN: begin
                if (!stall_i) begin
                    if (live_valid) begin
                        pc_d       = live_tgt;
                        flush_d    = 1'b1;
                        misalign_d = live_mis;
                    end else begin
                        pc_d = pc_q + INC_V;
                    end
                end else if (live_valid) begin
                    pend_tgt_d = live_tgt;
                    pend_lvl_d = live_lvl;
                    pend_mis_d = live_mis;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stall_i) begin
                    if (live_wins) begin
                        pend_tgt_d = live_tgt;
                        pend_lvl_d = live_lvl;
                        pend_mis_d = live_mis;
                    end
                end else begin
                    pc_d       = live_wins ? live_tgt : pend_tgt_q;
                    misalign_d = live_wins ? live_mis : pend_mis_q;
                    flush_d    = 1'b1;
                    pend_lvl_d = LVL_NONE;
                    pend_mis_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            pend_tgt_q    <= '0;
            pend_lvl_q    <= LVL_NONE;
            pend_mis_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            pend_tgt_q    <= pend_tgt_d;
            pend_lvl_q    <= pend_lvl_d;
            pend_mis_q    <= pend_mis_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign flush_o       = flush_q;
    assign pend_o        = (state_q == S_HOLD);
    assign misalign_o    = misalign_q;

endmodule
